// File: rtl/sevseg_pkg.sv
// Shared types and glyph constants for the seven-segment display scheduler.
// Segment order is {g,f,e,d,c,b,a}; all patterns are active-low.
package sevseg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

endpackage

// File: rtl/seven_seg_scheduler_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
// Covers the full 0-F range including the A b C d E F letter glyphs.
module hex_to_seg
    import sevseg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nib)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            4'hF: seg = GLYPH_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_scheduler.sv
// Round-robin owner of the 4-digit multiplexed display with a minimum hold.
// Define SEVSEG_LEAD_ZERO_BLANK_EN to blank leading zero digits.
module seven_seg_scheduler
    import sevseg_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int SCAN_W = 18,
    parameter int HOLD_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  req_code,
    output logic [N_REQ-1:0]     grant,
    output logic [10:0]          seg_data,
    output logic                 busy
);

    state_t              state;
    logic [1:0]          owner;
    logic [1:0]          rr_ptr;
    logic [1:0]          win_idx;
    logic [1:0]          next_ptr;
    logic                win_found;
    logic                expired;
    logic                own_req;
    logic                take;
    logic [N_REQ-1:0]    pool;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [15:0]         code;
    logic [1:0]          digit;
    logic [3:0]          nib;
    logic [3:0]          an;
    logic [6:0]          glyph;
    logic [6:0]          seg;

    // First set bit at or after ptr, wrapping; lowest offset wins.
    function automatic logic [2:0] arb(
        input logic [N_REQ-1:0] r,
        input logic [1:0]       ptr
    );
        logic [2:0]       res;
        logic [N_REQ-1:0] sh;
        int               idx;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N_REQ;
            sh  = r >> idx;
            if (sh[0])
                res = {1'b1, 2'(idx)};
        end
        return res;
    endfunction

    function automatic logic [15:0] code_of(input logic [1:0] idx);
        logic [15:0] c;
        c = '0;
        for (int i = 0; i < N_REQ; i++)
            if (idx == 2'(i))
                c = 16'(req_code >> (16 * i));
        return c;
    endfunction

    always_comb begin
        pool = req;
        if (state != IDLE)
            pool = req & ~grant;
        {win_found, win_idx} = arb(pool, rr_ptr);
        expired  = (state == HOLD) || (state == SHOW && &hold_cnt);
        own_req  = |(req & grant);
        take     = win_found && (state == IDLE || expired);
        next_ptr = (win_idx == 2'(N_REQ - 1)) ? 2'd0 : win_idx + 2'd1;
    end

    assign busy  = (state != IDLE);
    assign digit = scan_cnt[SCAN_W-1 -: 2];
    assign nib   = 4'(code >> {digit, 2'b00});
    assign an    = ~(4'b0001 << digit);

    hex_to_seg u_hex (
        .nib (nib),
        .seg (glyph)
    );

`ifdef SEVSEG_LEAD_ZERO_BLANK_EN
    logic lead;

    // A digit is leading when it and every higher nibble are zero.
    always_comb begin
        lead = 1'b0;
        if (digit != 2'd0)
            lead = ((code >> {digit, 2'b00}) == 16'h0);
        seg = lead ? SEG_OFF : glyph;
    end
`else
    assign seg = glyph;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            scan_cnt <= '0;
            code     <= '0;
            seg_data <= {AN_OFF, SEG_OFF};
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
            seg_data <= (state == IDLE) ? {AN_OFF, SEG_OFF} : {an, seg};
            if (take) begin
                state    <= SHOW;
                owner    <= win_idx;
                grant    <= N_REQ'(1) << win_idx;
                code     <= code_of(win_idx);
                hold_cnt <= '0;
                rr_ptr   <= next_ptr;
            end else if (state == SHOW && !expired) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end else if (expired && own_req) begin
                state    <= HOLD;
                hold_cnt <= hold_cnt + HOLD_W'(1);
                if (state == HOLD)
                    code <= code_of(owner);
            end else if (expired) begin
                state <= IDLE;
                grant <= '0;
            end
        end
    end

endmodule
